// File: rtl/status_flags_unit.sv
`default_nettype none
// ============================================================================
// Module   : status_flags_unit
// Brief    : NZCV status register with per-flag write mask, save/restore
//            stack and B.cond evaluator for the execute stage.
// Revision : 1.0  initial release
// ============================================================================
module status_flags_unit #(
    parameter int WIDTH       = 32,
    parameter int STACK_DEPTH = 4,
    parameter int FORWARD     = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               negative_in,
    input  logic                               zero_in,
    input  logic                               carry_in,
    input  logic                               overflow_in,
    input  logic                               update_sreg,
    input  logic [3:0]                         flag_mask,
    input  logic                               push,
    input  logic                               pop,
    input  logic                               clear_err,
    input  logic [3:0]                         cond,
    output logic                               negative_out,
    output logic                               zero_out,
    output logic                               carry_out,
    output logic                               overflow_out,
    output logic [WIDTH-1:0]                   sreg,
    output logic                               cond_true,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stack_ovf,
    output logic                               stack_unf
);

    localparam int              c_cnt_w = $clog2(STACK_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(STACK_DEPTH);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    // Flags are held as {N,Z,C,V}
    logic [3:0]         r_flags;
    logic [c_cnt_w-1:0] r_count;
    logic               r_ovf;
    logic               r_unf;
    // Sized to the full index range so count-derived indices never go out of bounds
    logic [3:0]         r_stack [0:(2**c_cnt_w)-1];

    logic [3:0]         w_in_flags;
    logic [3:0]         w_upd_flags;
    logic [3:0]         w_next_flags;
    logic [3:0]         w_eval_flags;
    logic [c_cnt_w-1:0] w_next_count;
    logic [c_cnt_w-1:0] w_top_idx;
    logic [c_cnt_w-1:0] w_wr_idx;
    logic               w_stack_we;
    logic               w_set_ovf;
    logic               w_set_unf;
    logic               w_full;
    logic               w_empty;
    logic               w_n, w_z, w_c, w_v;

    assign w_in_flags  = {negative_in, zero_in, carry_in, overflow_in};
    assign w_upd_flags = update_sreg ? ((flag_mask & w_in_flags) | (~flag_mask & r_flags))
                                     : r_flags;
    assign w_full      = (r_count == c_depth);
    assign w_empty     = (r_count == '0);
    assign w_top_idx   = r_count - c_one;

    always_comb begin
        w_next_flags = w_upd_flags;
        w_next_count = r_count;
        w_stack_we   = 1'b0;
        w_wr_idx     = r_count;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        if (pop && !w_empty) begin
            w_next_flags = r_stack[w_top_idx];
            if (push) begin
                // Swap: top takes the pre-edge flags, depth is unchanged
                w_stack_we = 1'b1;
                w_wr_idx   = w_top_idx;
            end else begin
                w_next_count = r_count - c_one;
            end
        end else if (push) begin
            if (!w_full) begin
                w_stack_we   = 1'b1;
                w_next_count = r_count + c_one;
            end else begin
                w_set_ovf = 1'b1;
            end
        end else if (pop) begin
            w_set_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_flags <= w_next_flags;
            r_count <= w_next_count;
            r_ovf   <= w_set_ovf | (r_ovf & ~clear_err);
            r_unf   <= w_set_unf | (r_unf & ~clear_err);
        end
    end

    always_ff @(posedge clk) begin
        if (w_stack_we) begin
            r_stack[w_wr_idx] <= r_flags;
        end
    end

    assign w_eval_flags = ((FORWARD != 0) && update_sreg && !pop && !reset) ? w_upd_flags
                                                                            : r_flags;
    assign {w_n, w_z, w_c, w_v} = w_eval_flags;

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            4'd0:    cond_true = w_z;
            4'd1:    cond_true = !w_z;
            4'd2:    cond_true = w_c;
            4'd3:    cond_true = !w_c;
            4'd4:    cond_true = w_n;
            4'd5:    cond_true = !w_n;
            4'd6:    cond_true = w_v;
            4'd7:    cond_true = !w_v;
            4'd8:    cond_true = w_c & !w_z;
            4'd9:    cond_true = !(w_c & !w_z);
            4'd10:   cond_true = (w_n == w_v);
            4'd11:   cond_true = (w_n != w_v);
            4'd12:   cond_true = !w_z & (w_n == w_v);
            4'd13:   cond_true = !(!w_z & (w_n == w_v));
            default: cond_true = 1'b1;
        endcase
    end

    assign negative_out = r_flags[3];
    assign zero_out     = r_flags[2];
    assign carry_out    = r_flags[1];
    assign overflow_out = r_flags[0];
    assign stack_count  = r_count;
    assign stack_full   = w_full;
    assign stack_empty  = w_empty;
    assign stack_ovf    = r_ovf;
    assign stack_unf    = r_unf;

    generate
        if (WIDTH > 4) begin : g_sreg_pad
            assign sreg = {r_flags, {(WIDTH-4){1'b0}}};
        end else begin : g_sreg_bare
            assign sreg = r_flags;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_status_flags_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_flags_unit
// Brief    : Directed and randomized checks of status_flags_unit (FORWARD=0
//            and FORWARD=1 instances side by side) against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_status_flags_unit;

    localparam int c_depth = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] flags_in;
    logic       update_sreg, push, pop, clear_err;
    logic [3:0] flag_mask, cond;

    logic        n0, z0, c0, v0, ct0, full0, empty0, ovf0, unf0;
    logic        n1, z1, c1, v1, ct1, full1, empty1, ovf1, unf1;
    logic [31:0] sreg0, sreg1;
    logic [2:0]  cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] m_flags;
    logic [3:0] m_q[$];
    logic       m_ovf, m_unf;

    always #5 clk = ~clk;

    status_flags_unit #(.WIDTH(32), .STACK_DEPTH(c_depth), .FORWARD(0)) dut (
        .clk(clk), .reset(reset),
        .negative_in(flags_in[3]), .zero_in(flags_in[2]),
        .carry_in(flags_in[1]), .overflow_in(flags_in[0]),
        .update_sreg(update_sreg), .flag_mask(flag_mask),
        .push(push), .pop(pop), .clear_err(clear_err), .cond(cond),
        .negative_out(n0), .zero_out(z0), .carry_out(c0), .overflow_out(v0),
        .sreg(sreg0), .cond_true(ct0), .stack_count(cnt0),
        .stack_full(full0), .stack_empty(empty0), .stack_ovf(ovf0), .stack_unf(unf0)
    );

    status_flags_unit #(.WIDTH(32), .STACK_DEPTH(c_depth), .FORWARD(1)) dut_fwd (
        .clk(clk), .reset(reset),
        .negative_in(flags_in[3]), .zero_in(flags_in[2]),
        .carry_in(flags_in[1]), .overflow_in(flags_in[0]),
        .update_sreg(update_sreg), .flag_mask(flag_mask),
        .push(push), .pop(pop), .clear_err(clear_err), .cond(cond),
        .negative_out(n1), .zero_out(z1), .carry_out(c1), .overflow_out(v1),
        .sreg(sreg1), .cond_true(ct1), .stack_count(cnt1),
        .stack_full(full1), .stack_empty(empty1), .stack_ovf(ovf1), .stack_unf(unf1)
    );

    function automatic logic m_cond(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !(cy && !z);
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] m_masked();
        logic [3:0] f;
        f = m_flags;
        for (int i = 0; i < 4; i++)
            if (update_sreg && flag_mask[i]) f[i] = flags_in[i];
        return f;
    endfunction

    // Expected cond_true pair {FORWARD=0, FORWARD=1} for the current inputs
    function automatic logic [1:0] m_cond_pair();
        logic [3:0] fwd;
        fwd = (update_sreg && !pop) ? m_masked() : m_flags;
        return {m_cond(m_flags, cond), m_cond(fwd, cond)};
    endfunction

    function automatic void m_step();
        logic [3:0] t;
        logic       new_ovf, new_unf;
        new_ovf = 1'b0;
        new_unf = 1'b0;
        if (pop && m_q.size() > 0 && push) begin
            t = m_q[m_q.size()-1];
            m_q[m_q.size()-1] = m_flags;
            m_flags = t;
        end else if (pop && m_q.size() > 0) begin
            m_flags = m_q.pop_back();
        end else begin
            t = m_masked();
            if (push) begin
                if (m_q.size() < c_depth) m_q.push_back(m_flags);
                else new_ovf = 1'b1;
            end else if (pop) begin
                new_unf = 1'b1;
            end
            m_flags = t;
        end
        m_ovf = new_ovf || (m_ovf && !clear_err);
        m_unf = new_unf || (m_unf && !clear_err);
    endfunction

    function automatic void m_reset();
        m_flags = 4'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic logic [85:0] obs_state();
        return {n0, z0, c0, v0, cnt0, full0, empty0, ovf0, unf0, sreg0,
                n1, z1, c1, v1, cnt1, full1, empty1, ovf1, unf1, sreg1};
    endfunction

    function automatic logic [85:0] exp_state();
        logic [42:0] e;
        e = {m_flags, 3'(m_q.size()), m_q.size() == c_depth, m_q.size() == 0,
             m_ovf, m_unf, m_flags, 28'h0};
        return {e, e};
    endfunction

    task automatic drive(input logic u, input logic [3:0] m, input logic [3:0] fi,
                         input logic pu, input logic po, input logic cl, input logic [3:0] cd);
        update_sreg = u;
        flag_mask   = m;
        flags_in    = fi;
        push        = pu;
        pop         = po;
        clear_err   = cl;
        cond        = cd;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 4'h0, 4'h0, 0, 0, 0, 4'd0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs_state() !== exp_state())
            begin bad++; $display("FAIL reset_state got=%h want=%h", obs_state(), exp_state()); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // Build flags=1111 with two stacked entries, then reset mid-cycle
        drive(1, 4'hF, 4'hF, 0, 0, 0, 4'd0);
        tick();
        drive(0, 4'h0, 4'h0, 1, 0, 0, 4'd0);
        tick();
        tick();
        drive(0, 4'h0, 4'h0, 0, 0, 0, 4'd0);
        total++;
        if ({n0, z0, c0, v0, cnt0} !== {4'hF, 3'd2})
            begin bad++; $display("FAIL pre_reset got=%h want=%h", {n0, z0, c0, v0, cnt0}, {4'hF, 3'd2}); end
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        total++;
        if (obs_state() !== exp_state())
            begin bad++; $display("FAIL async_reset got=%h want=%h", obs_state(), exp_state()); end
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_update();
        drive(1, 4'b0100, 4'hF, 0, 0, 0, 4'd0);
        tick();
        drive(0, 4'h0, 4'h0, 0, 0, 0, 4'd0);
        #1;
        total++;
        if ({sreg0, ct0} !== {32'h4000_0000, 1'b1})
            begin bad++; $display("FAIL update_eq got=%h want=%h", {sreg0, ct0}, {32'h4000_0000, 1'b1}); end
        cond = 4'd1;
        #1;
        total++;
        if (ct0 !== 1'b0)
            begin bad++; $display("FAIL update_ne got=%b want=0", ct0); end
        drive(1, 4'b0000, 4'hB, 0, 0, 0, 4'd1);
        tick();
        total++;
        if (obs_state() !== exp_state() || sreg0 !== 32'h4000_0000)
            begin bad++; $display("FAIL mask_zero got=%h want=%h", obs_state(), exp_state()); end
    endtask

    task automatic test_push_pop();
        drive(1, 4'hF, 4'b1010, 0, 0, 0, 4'd0);
        tick();
        drive(1, 4'hF, 4'b0101, 1, 0, 0, 4'd0);
        tick();
        total++;
        if ({n0, z0, c0, v0, cnt0} !== {4'b0101, 3'd1} || obs_state() !== exp_state())
            begin bad++; $display("FAIL push_update got=%h want=%h", obs_state(), exp_state()); end
        drive(0, 4'h0, 4'h0, 0, 1, 0, 4'd0);
        tick();
        total++;
        if ({n0, z0, c0, v0, cnt0} !== {4'b1010, 3'd0} || obs_state() !== exp_state())
            begin bad++; $display("FAIL pop_restore got=%h want=%h", obs_state(), exp_state()); end
    endtask

    task automatic test_stack_limits();
        drive(1, 4'hF, 4'b0011, 0, 0, 0, 4'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'hF, 4'(i + 8), 1, 0, 0, 4'd0);
            tick();
        end
        total++;
        if ({cnt0, full0, ovf0} !== {3'd4, 1'b1, 1'b1} || obs_state() !== exp_state())
            begin bad++; $display("FAIL overflow got=%h want=%h", obs_state(), exp_state()); end
        drive(0, 4'h0, 4'h0, 1, 0, 1, 4'd0);
        tick();
        total++;
        if (ovf0 !== 1'b1 || obs_state() !== exp_state())
            begin bad++; $display("FAIL clear_vs_error got=%h want=%h", obs_state(), exp_state()); end
        drive(0, 4'h0, 4'h0, 0, 0, 1, 4'd0);
        tick();
        total++;
        if (ovf0 !== 1'b0 || obs_state() !== exp_state())
            begin bad++; $display("FAIL clear_err got=%h want=%h", obs_state(), exp_state()); end
        for (int i = 0; i < 5; i++) begin
            drive(0, 4'h0, 4'h0, 0, 1, 0, 4'd0);
            tick();
            if (i == 3) begin
                total++;
                if ({n0, z0, c0, v0, empty0} !== {4'b0011, 1'b1})
                    begin bad++; $display("FAIL fourth_pop got=%h want=%h", {n0, z0, c0, v0, empty0}, {4'b0011, 1'b1}); end
            end
        end
        total++;
        if (unf0 !== 1'b1 || obs_state() !== exp_state())
            begin bad++; $display("FAIL underflow got=%h want=%h", obs_state(), exp_state()); end
        drive(0, 4'h0, 4'h0, 0, 0, 1, 4'd0);
        tick();
    endtask

    task automatic test_swap();
        drive(1, 4'hF, 4'b1000, 0, 0, 0, 4'd0);
        tick();
        drive(1, 4'hF, 4'b0001, 1, 0, 0, 4'd0);
        tick();
        drive(1, 4'hF, 4'b1111, 1, 1, 0, 4'd0);
        tick();
        total++;
        if ({n0, z0, c0, v0, cnt0, unf0} !== {4'b1000, 3'd1, 1'b0} || obs_state() !== exp_state())
            begin bad++; $display("FAIL swap got=%h want=%h", obs_state(), exp_state()); end
        drive(0, 4'h0, 4'h0, 0, 1, 0, 4'd0);
        tick();
        total++;
        if ({n0, z0, c0, v0, cnt0} !== {4'b0001, 3'd0})
            begin bad++; $display("FAIL swap_top got=%h want=%h", {n0, z0, c0, v0, cnt0}, {4'b0001, 3'd0}); end
        drive(1, 4'hF, 4'b0110, 1, 1, 0, 4'd0);
        tick();
        total++;
        if (obs_state() !== exp_state() || unf0 !== 1'b0 || cnt0 !== 3'd1)
            begin bad++; $display("FAIL pushpop_empty got=%h want=%h", obs_state(), exp_state()); end
        drive(0, 4'h0, 4'h0, 0, 1, 0, 4'd0);
        tick();
    endtask

    task automatic test_forward();
        drive(1, 4'hF, 4'b0000, 0, 0, 0, 4'd0);
        tick();
        drive(1, 4'hF, 4'b1000, 0, 0, 0, 4'd11);
        #1;
        total++;
        if ({ct0, ct1} !== 2'b01)
            begin bad++; $display("FAIL forward_same got=%b want=01", {ct0, ct1}); end
        tick();
        drive(0, 4'h0, 4'h0, 0, 0, 0, 4'd11);
        #1;
        total++;
        if ({ct0, ct1} !== 2'b11)
            begin bad++; $display("FAIL forward_next got=%b want=11", {ct0, ct1}); end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                  r < 3 || r == 6, (r >= 3 && r <= 5) || r == 6,
                  $urandom_range(0, 15) == 0, 4'($urandom));
            #1;
            total++;
            if ({ct0, ct1} !== m_cond_pair())
                begin bad++; $display("FAIL rand_cond[%0d] got=%b want=%b", i, {ct0, ct1}, m_cond_pair()); end
            tick();
            total++;
            if (obs_state() !== exp_state())
                begin bad++; $display("FAIL rand_state[%0d] got=%h want=%h", i, obs_state(), exp_state()); end
        end
    endtask

    initial begin
        test_reset();
        test_update();
        test_push_pop();
        test_stack_limits();
        test_swap();
        test_forward();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
